// File: rtl/fixed_dot_accumulator.sv
// fixed_dot_accumulator: streaming signed fixed-point dot product with a joined input handshake and registered valid/ready output
module fixed_dot_accumulator #(
  parameter int DATA_IN_0_PRECISION_0  = 16,
  parameter int DATA_IN_0_PRECISION_1  = 3,
  parameter int WEIGHT_PRECISION_0     = 16,
  parameter int WEIGHT_PRECISION_1     = 3,
  parameter int PARALLELISM            = 4,
  parameter int IN_DEPTH               = 8,
  parameter int DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0 + $clog2(PARALLELISM) + $clog2(IN_DEPTH),
  parameter int DATA_OUT_0_PRECISION_1 = DATA_IN_0_PRECISION_1 + WEIGHT_PRECISION_1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [PARALLELISM],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  input  logic [WEIGHT_PRECISION_0-1:0]     weight [PARALLELISM],
  input  logic                              weight_valid,
  output logic                              weight_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);
  localparam int PW = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0;
  localparam int OW = DATA_OUT_0_PRECISION_0;
  localparam int CW = IN_DEPTH > 1 ? $clog2(IN_DEPTH) : 1;
  logic                 stall, fire, load, cnt_last;
  logic                 s1_valid_q, s1_last_q, fresh_q, out_valid_q;
  logic [CW-1:0]        cnt_q;
  logic signed [PW-1:0] prod_q [PARALLELISM];
  logic signed [OW-1:0] acc_q, out_q, tree_sum, acc_d;
  assign stall            = out_valid_q & ~data_out_0_ready;
  assign fire             = data_in_0_valid & weight_valid & ~stall & ~rst;
  assign data_in_0_ready  = weight_valid & ~stall & ~rst;
  assign weight_ready     = data_in_0_valid & ~stall & ~rst;
  assign load             = s1_valid_q & s1_last_q & ~stall;
  assign cnt_last         = cnt_q == CW'(IN_DEPTH - 1);
  assign data_out_0       = out_q;
  assign data_out_0_valid = out_valid_q;
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < PARALLELISM; i++) tree_sum = tree_sum + OW'(prod_q[i]);
    acc_d = (fresh_q ? '0 : acc_q) + tree_sum;
  end
  always_ff @(posedge clk)
    if (fire)
      for (int i = 0; i < PARALLELISM; i++) prod_q[i] <= $signed(data_in_0[i]) * $signed(weight[i]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      fresh_q     <= 1'b1;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= load | (out_valid_q & ~data_out_0_ready);
      if (!stall) begin
        s1_valid_q <= fire;
        s1_last_q  <= fire & cnt_last;
        if (fire) cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
        if (s1_valid_q) begin
          acc_q   <= s1_last_q ? '0 : acc_d;
          fresh_q <= s1_last_q;
          if (s1_last_q) out_q <= acc_d;
        end
      end
    end
  end
endmodule
